// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_t;

   localparam logic [31:0] IMEM_BASE  = 32'hBFC00000;
   localparam int unsigned IMEM_BYTES = 4096;
   localparam int unsigned OFF_WIDTH  = 13;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed image into the instruction memory and
// holds the CPU in reset until a verified image is present.
module imem_loader
   import imem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = IMEM_BASE,
   parameter int unsigned MAX_BYTES = IMEM_BYTES,
   parameter int unsigned LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [7:0]           s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic                 mem_we,
   output logic [31:0]          mem_addr,
   output logic [7:0]           mem_wdata,
   output logic                 cpu_hold,
   output logic                 load_done,
   output logic                 load_err,
   output logic [OFF_WIDTH-1:0] bytes_loaded
);

   loader_state_t        state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [OFF_WIDTH-1:0] off_q, off_d;
   logic [7:0]           csum_q, csum_d;
   logic                 we_q, we_d;
   logic [31:0]          addr_q, addr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 xfer;

   assign xfer = s_valid && s_ready;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      off_d   = off_q;
      csum_d  = csum_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      s_ready = 1'b0;

      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LEN0;
               len_d   = '0;
               off_d   = '0;
               csum_d  = 8'h00;
            end
         end
         LEN0: begin
            s_ready = 1'b1;
            if (xfer) begin
               len_d   = LEN_WIDTH'(s_data);
               state_d = LEN1;
            end
         end
         LEN1: begin
            s_ready = 1'b1;
            if (xfer) begin
               len_d = len_q | (LEN_WIDTH'(s_data) << 8);
               if (32'(len_d) > MAX_BYTES) begin
                  state_d = ERR;
               end else if (len_d == '0) begin
                  state_d = CSUM;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            s_ready = 1'b1;
            if (xfer) begin
               we_d    = 1'b1;
               wdata_d = s_data;
               addr_d  = BASE_ADDR + 32'(off_q);
               csum_d  = csum_q ^ s_data;
               off_d   = off_q + 1'b1;
               // off_d now counts bytes written; equal to N means the last byte just went out.
               if (LEN_WIDTH'(off_d) == len_q) begin
                  state_d = CSUM;
               end
            end
         end
         CSUM: begin
            s_ready = 1'b1;
            if (xfer) begin
               state_d = (s_data == csum_q) ? DONE : ERR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         off_q   <= '0;
         csum_q  <= 8'h00;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         wdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         off_q   <= off_d;
         csum_q  <= csum_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem_we       = we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign cpu_hold     = (state_q != DONE);
   assign load_done    = (state_q == DONE);
   assign load_err     = (state_q == ERR);
   assign bytes_loaded = off_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a cycle-by-cycle vector table plus sequences for
// backpressure and reset during a load.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'hBFC00000;

   typedef struct packed {
      logic        s_ready;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [7:0]  mem_wdata;
      logic        cpu_hold;
      logic        load_done;
      logic        load_err;
      logic [12:0] bytes_loaded;
   } outs_t;

   typedef struct packed {
      logic       start;
      logic       valid;
      logic [7:0] data;
      outs_t      exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;
   logic [12:0] bytes_loaded;

   int          n_vec = 0;
   int          n_err = 0;
   vec_t        vecs[$];

   bit          mon_en = 1'b0;
   int          wr_cnt = 0;
   logic [7:0]  exp_data [16];

   imem_loader dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .cpu_hold    (cpu_hold),
      .load_done   (load_done),
      .load_err    (load_err),
      .bytes_loaded(bytes_loaded)
   );

   always #5 clk = ~clk;

   function automatic outs_t o(bit rdy, bit we, logic [11:0] off, logic [7:0] wd,
                               bit done, bit err, logic [12:0] bl);
      outs_t r;
      r.s_ready      = rdy;
      r.mem_we       = we;
      r.mem_addr     = BASE + {20'h0, off};
      r.mem_wdata    = wd;
      r.cpu_hold     = ~done;
      r.load_done    = done;
      r.load_err     = err;
      r.bytes_loaded = bl;
      return r;
   endfunction

   function automatic void v(bit st, bit vl, logic [7:0] d, bit rdy, bit we, logic [11:0] off,
                             logic [7:0] wd, bit done, bit err, logic [12:0] bl);
      vec_t x;
      x.start = st;
      x.valid = vl;
      x.data  = d;
      x.exp   = o(rdy, we, off, wd, done, err, bl);
      vecs.push_back(x);
   endfunction

   task automatic check(input string name, input outs_t exp);
      outs_t act;
      act.s_ready      = s_ready;
      act.mem_we       = mem_we;
      act.mem_addr     = mem_addr;
      act.mem_wdata    = mem_wdata;
      act.cpu_hold     = cpu_hold;
      act.load_done    = load_done;
      act.load_err     = load_err;
      act.bytes_loaded = bytes_loaded;
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b bl=%0d; want rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b bl=%0d",
                  name, act.s_ready, act.mem_we, act.mem_addr, act.mem_wdata, act.cpu_hold,
                  act.load_done, act.load_err, act.bytes_loaded, exp.s_ready, exp.mem_we,
                  exp.mem_addr, exp.mem_wdata, exp.cpu_hold, exp.load_done, exp.load_err,
                  exp.bytes_loaded);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Single-beat transfer; the loader must already be ready in a receiving state.
   task automatic send(input logic [7:0] b);
      s_valid = 1'b1;
      s_data  = b;
      check_bit("send_ready", s_ready, 1'b1);
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   // Write monitor for the backpressure frame: contiguous addresses, expected data.
   always @(negedge clk) begin
      if (mon_en && mem_we) begin
         n_vec++;
         if (wr_cnt >= 16) begin
            n_err++;
            $display("FAIL bp_extra_write: got write #%0d at %h want at most 16", wr_cnt + 1,
                     mem_addr);
         end else if (mem_addr !== BASE + 32'(wr_cnt) || mem_wdata !== exp_data[wr_cnt]) begin
            n_err++;
            $display("FAIL bp_write%0d: got addr=%h data=%h want addr=%h data=%h", wr_cnt,
                     mem_addr, mem_wdata, BASE + 32'(wr_cnt), exp_data[wr_cnt]);
         end
         wr_cnt++;
      end
   end

   initial begin
      logic [7:0] frame [19];
      logic [7:0] x;
      int         idx;
      int         cyc;
      bit         xfer;

      // Nominal load, start ignored mid-frame, s_valid ignored in DONE.
      v(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
      v(0, 1, 8'h04, 1, 0, 0, 8'h00, 0, 0, 0);
      v(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
      v(0, 1, 8'h13, 1, 1, 0, 8'h13, 0, 0, 1);
      v(1, 1, 8'h05, 1, 1, 1, 8'h05, 0, 0, 2);
      v(0, 1, 8'hA0, 1, 1, 2, 8'hA0, 0, 0, 3);
      v(0, 1, 8'h00, 1, 1, 3, 8'h00, 0, 0, 4);
      v(0, 1, 8'hB6, 0, 0, 3, 8'h00, 1, 0, 4);
      v(0, 1, 8'h55, 0, 0, 3, 8'h00, 1, 0, 4);
      // Reload with bad checksum and a stall cycle.
      v(1, 0, 8'h00, 1, 0, 3, 8'h00, 0, 0, 0);
      v(0, 1, 8'h04, 1, 0, 3, 8'h00, 0, 0, 0);
      v(0, 1, 8'h00, 1, 0, 3, 8'h00, 0, 0, 0);
      v(0, 1, 8'h13, 1, 1, 0, 8'h13, 0, 0, 1);
      v(0, 1, 8'h05, 1, 1, 1, 8'h05, 0, 0, 2);
      v(0, 0, 8'h77, 1, 0, 1, 8'h05, 0, 0, 2);
      v(0, 1, 8'hA0, 1, 1, 2, 8'hA0, 0, 0, 3);
      v(0, 1, 8'h00, 1, 1, 3, 8'h00, 0, 0, 4);
      v(0, 1, 8'hB7, 0, 0, 3, 8'h00, 0, 1, 4);
      // Oversize header N=4097.
      v(1, 0, 8'h00, 1, 0, 3, 8'h00, 0, 0, 0);
      v(0, 1, 8'h01, 1, 0, 3, 8'h00, 0, 0, 0);
      v(0, 1, 8'h10, 0, 0, 3, 8'h00, 0, 1, 0);
      // Zero length, then a one-byte image.
      v(1, 0, 8'h00, 1, 0, 3, 8'h00, 0, 0, 0);
      v(0, 1, 8'h00, 1, 0, 3, 8'h00, 0, 0, 0);
      v(0, 1, 8'h00, 1, 0, 3, 8'h00, 0, 0, 0);
      v(0, 1, 8'h00, 0, 0, 3, 8'h00, 1, 0, 0);
      v(1, 0, 8'h00, 1, 0, 3, 8'h00, 0, 0, 0);
      v(0, 1, 8'h01, 1, 0, 3, 8'h00, 0, 0, 0);
      v(0, 1, 8'h00, 1, 0, 3, 8'h00, 0, 0, 0);
      v(0, 1, 8'hFF, 1, 1, 0, 8'hFF, 0, 0, 1);
      v(0, 1, 8'hFF, 0, 0, 0, 8'hFF, 1, 0, 1);

      repeat (2) @(posedge clk);
      #1 check("reset_async", o(0, 0, 0, 8'h00, 0, 0, 0));
      rst = 1'b0;
      @(posedge clk);
      #1 check("reset_idle", o(0, 0, 0, 8'h00, 0, 0, 0));

      foreach (vecs[i]) begin
         start   = vecs[i].start;
         s_valid = vecs[i].valid;
         s_data  = vecs[i].data;
         @(posedge clk);
         #1;
         start   = 1'b0;
         s_valid = 1'b0;
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Backpressure: 16-byte frame with random gaps on s_valid.
      x = 8'h00;
      frame[0] = 8'h10;
      frame[1] = 8'h00;
      for (int i = 0; i < 16; i++) begin
         exp_data[i]  = 8'(i * 37 + 11);
         frame[i + 2] = exp_data[i];
         x            = x ^ exp_data[i];
      end
      frame[18] = x;
      wr_cnt = 0;
      mon_en = 1'b1;
      pulse_start();
      idx = 0;
      cyc = 0;
      while (idx < 19 && cyc < 1000) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = frame[idx];
         xfer    = s_valid && s_ready;
         @(posedge clk);
         #1;
         if (xfer) idx++;
         cyc++;
      end
      s_valid = 1'b0;
      if (idx < 19) begin
         n_vec++;
         n_err++;
         $display("FAIL bp_budget: got %0d bytes sent want 19", idx);
      end
      @(posedge clk);
      #1 mon_en = 1'b0;
      n_vec++;
      if (wr_cnt != 16) begin
         n_err++;
         $display("FAIL bp_write_count: got %0d want 16", wr_cnt);
      end
      check("bp_done", o(0, 0, 15, exp_data[15], 1, 0, 16));

      // Reset after the second data byte of an 8-byte frame, then a clean reload.
      pulse_start();
      send(8'h08);
      send(8'h00);
      send(8'h21);
      send(8'h42);
      rst = 1'b1;
      #1 check("midload_reset", o(0, 0, 0, 8'h00, 0, 0, 0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 check("midload_idle", o(0, 0, 0, 8'h00, 0, 0, 0));
      pulse_start();
      send(8'h08);
      send(8'h00);
      x = 8'h00;
      for (int i = 0; i < 8; i++) begin
         send(8'(8'hC0 + i));
         x = x ^ 8'(8'hC0 + i);
      end
      send(x);
      check("reload_done", o(0, 0, 7, 8'hC7, 1, 0, 8));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
